// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one result per interior pixel out.
// Two line buffers plus a two-column shift register form the window; the result pipeline is two stages.
module sobel_stream #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 10,
   parameter int COL_SIZE  = 10,
   parameter int SHIFT     = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [WORD_SIZE-1:0] in_pixel,
   input  logic                 mode,
   input  logic [WORD_SIZE+2:0] threshold,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 frame_done
);

   localparam int CW = $clog2(ROW_SIZE);
   localparam int RW = $clog2(COL_SIZE);
   localparam int SW = WORD_SIZE + 2;
   localparam int MW = WORD_SIZE + 3;
   localparam logic [CW-1:0] C_LAST = CW'(ROW_SIZE - 1);
   localparam logic [RW-1:0] R_LAST = RW'(COL_SIZE - 1);

   typedef logic [WORD_SIZE-1:0] word_t;

   logic [CW-1:0] col_q, col;
   logic [RW-1:0] row_q, row;
   word_t         lb_top [ROW_SIZE];
   word_t         lb_mid [ROW_SIZE];
   word_t         win    [3][2];
   word_t         p      [3][3];
   logic          win_ok;
   logic          frame_mode;
   logic [MW-1:0] frame_thr;

   logic [SW-1:0] s1_gxp, s1_gxn, s1_gyp, s1_gyn;
   logic          s1_valid, s1_last, s1_mode;
   logic [MW-1:0] s1_thr;

   logic [SW-1:0] gx_abs, gy_abs;
   logic [MW-1:0] mag, scaled;
   word_t         result;

   function automatic logic [SW-1:0] tap(input word_t a, input word_t b, input word_t c);
      return SW'(a) + (SW'(b) << 1) + SW'(c);
   endfunction

   // Position of the pixel being accepted; in_sof forces it to the frame origin.
   // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      col    = in_sof ? '0 : col_q;
      row    = in_sof ? '0 : row_q;
      win_ok = in_valid && (row >= RW'(2)) && (col >= CW'(2));
      for (int i = 0; i < 3; i++) begin
         p[i][0] = win[i][0];
         p[i][1] = win[i][1];
      end
      p[0][2] = lb_top[col];
      p[1][2] = lb_mid[col];
      p[2][2] = in_pixel;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q      <= '0;
         row_q      <= '0;
         frame_mode <= 1'b0;
         frame_thr  <= '0;
      end else if (in_valid) begin
         if (col == C_LAST) begin
            col_q <= '0;
            row_q <= (row == R_LAST) ? '0 : row + 1'b1;
         end else begin
            col_q <= col + 1'b1;
            row_q <= row;
         end
         if (row == '0 && col == '0) begin
            frame_mode <= mode;
            frame_thr  <= threshold;
         end
      end
   end

   // NOTE: line buffers and window carry no reset; stale contents are never used because rows 0-1 are gated.
   always_ff @(posedge clock) begin
      if (in_valid) begin
         lb_top[col] <= lb_mid[col];
         lb_mid[col] <= in_pixel;
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= p[i][2];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (win_ok) begin
         s1_gxp  <= tap(p[0][2], p[1][2], p[2][2]);
         s1_gxn  <= tap(p[0][0], p[1][0], p[2][0]);
         s1_gyp  <= tap(p[2][0], p[2][1], p[2][2]);
         s1_gyn  <= tap(p[0][0], p[0][1], p[0][2]);
         s1_mode <= frame_mode;
         s1_thr  <= frame_thr;
      end
   end

   always_comb begin
      gx_abs = (s1_gxp >= s1_gxn) ? s1_gxp - s1_gxn : s1_gxn - s1_gxp;
      gy_abs = (s1_gyp >= s1_gyn) ? s1_gyp - s1_gyn : s1_gyn - s1_gyp;
      mag    = MW'(gx_abs) + MW'(gy_abs);
      scaled = mag >> SHIFT;
      if (s1_mode)
         result = (mag >= s1_thr) ? '1 : '0;
      else if (|scaled[MW-1:WORD_SIZE])
         result = '1;
      else
         result = scaled[WORD_SIZE-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_pixel  <= '0;
      end else begin
         s1_valid   <= win_ok;
         s1_last    <= win_ok && (row == R_LAST) && (col == C_LAST);
         out_valid  <= s1_valid;
         frame_done <= s1_valid && s1_last;
         if (s1_valid)
            out_pixel <= result;
      end
   end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter WORD_SIZE, default 8, pixel bit width.
REQ-002 Parameter ROW_SIZE, default 10, pixels per image row (>=3).
REQ-003 Parameter COL_SIZE, default 10, rows per frame (>=3).
REQ-004 Parameter SHIFT, default 2, right-shift applied to the magnitude in magnitude mode.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_pixel is accepted this cycle; no backpressure.
REQ-008 in_sof  input  1  qualified by in_valid; the accepted pixel is frame position (0,0).
REQ-009 in_pixel  input  WORD_SIZE  raster-order pixel, unsigned.
REQ-010 mode  input  1  0 = scaled magnitude, 1 = binary threshold.
REQ-011 threshold  input  WORD_SIZE+3  unsigned magnitude threshold for mode 1.
REQ-012 out_valid  output  1  out_pixel holds one interior-pixel result.
REQ-013 out_pixel  output  WORD_SIZE  edge result.
REQ-014 frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-015 Column counter c (0..ROW_SIZE-1) and row counter r (0..COL_SIZE-1) SHALL advance only on accepted pixels; c wraps to 0 and increments r; after (COL_SIZE-1,ROW_SIZE-1) both wrap to 0.
REQ-016 An accepted pixel with in_sof=1 SHALL be placed at (0,0) regardless of counter state; counters continue from (0,1).
REQ-017 Two line buffers of ROW_SIZE words SHALL hold the previous two rows; with the shift registers they form a 3x3 window p[0..2][0..2] (row 2 and col 2 = newest pixel).
REQ-018 A window SHALL be complete only when the accepted pixel is at r>=2 and c>=2; result corresponds to centre (r-1,c-1); no output for border pixels, giving (ROW_SIZE-2)*(COL_SIZE-2) outputs per frame.
REQ-019 Gx = (p0,2 + 2*p1,2 + p2,2) - (p0,0 + 2*p1,0 + p2,0); Gy = (p2,0 + 2*p2,1 + p2,2) - (p0,0 + 2*p0,1 + p0,2); computed without overflow.
REQ-020 mag = |Gx| + |Gy|, unsigned WORD_SIZE+3 bits (max 8*(2^WORD_SIZE-1)).
REQ-021 Mode 0: out_pixel = mag >> SHIFT, saturated to all ones when it exceeds 2^WORD_SIZE-1.
REQ-022 Mode 1: out_pixel = all ones when mag >= threshold, else 0.
REQ-023 mode and threshold SHALL be sampled on each accepted (0,0) pixel and held for that frame; changes mid-frame take effect next frame.
REQ-024 Pipeline: stage 1 registers the partial sums, stage 2 registers out_pixel; out_valid SHALL rise exactly 2 cycles after the in_valid cycle completing the window.
REQ-025 The pipeline SHALL advance every cycle; gaps in in_valid SHALL not alter results, only their timing.
REQ-026 frame_done SHALL pulse with the output for centre (COL_SIZE-2,ROW_SIZE-2).
REQ-027 Outputs for one frame SHALL never mix rows of the previous frame: rows r<2 of each frame are gated per REQ-018.

Reset
REQ-028 On reset_n low, out_valid, frame_done, out_pixel, counters, pipeline valids and sampled mode/threshold SHALL clear to 0 immediately.
REQ-029 Line-buffer and window contents need not be reset.
REQ-030 Reset mid-frame SHALL drop in-flight results; the first pixel accepted after release is (0,0).

Verification
REQ-031 Flat frame, all pixels 128, mode 0, 10x10 -> 64 outputs, all 0; frame_done once, with the 64th output.
REQ-032 Vertical step, cols 0-4 = 0, cols 5-9 = 255, mode 0, SHIFT 2 -> centre cols 4 and 5 = 255 (mag 1020), all other outputs 0.
REQ-033 Corner, pixel = 255 where r>=5 and c>=5, else 0, mode 0 -> centre (5,5) mag 1530, out 255 (saturated); centre (4,4) mag 510, out 127.
REQ-034 Vertical step, mode 1, threshold 1000 -> 255 at centre cols 4 and 5, 0 elsewhere; threshold changed to 2000 mid-frame -> no change until next frame, then all 0.
REQ-035 Vertical step with random 0-3 idle cycles between pixels -> same 64 values in the same order; each out_valid exactly 2 cycles after its completing pixel.
REQ-036 reset_n low after 37 pixels, then a full frame -> no output during reset; next frame gives exactly 64 correct outputs; in_sof on pixel 15 of a frame restarts the count at (0,0).
